qdiv_hs: RTL and testbench
==========================

QDIV_HS -- requirements
Module: qdiv_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 32: total word width; bit WIDTH-1 is sign, bits WIDTH-2:0 are magnitude (sign-magnitude).
REQ-002 SHALL have parameter FBITS, default 16: fractional bits of magnitude; legal range 1..WIDTH-2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port dividend  input  WIDTH  sign-magnitude fixed-point numerator.
REQ-008 SHALL have port divisor  input  WIDTH  sign-magnitude fixed-point denominator.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port quotient  output  WIDTH  sign-magnitude result, same format as inputs.
REQ-012 SHALL have port div_zero  output  1  divisor magnitude was zero; qualified by out_valid.
REQ-013 SHALL have port overflow  output  1  result magnitude saturated; qualified by out_valid.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL accept operands on a rising edge with in_valid & in_ready, registering signs and magnitudes; later input changes have no effect.
REQ-017 SHALL compute restoring division of N = |dividend| << FBITS (WIDTH-1+FBITS bits) by D = |divisor|, one quotient bit per CALC cycle, ITER = WIDTH-1+FBITS iterations (47 by default).
REQ-018 SHALL enter DONE on the edge completing the last iteration: acceptance at edge k gives out_valid high after edge k+ITER.
REQ-019 SHALL set overflow when the full quotient >= 2^(WIDTH-1), forcing magnitude to all ones.
REQ-020 SHALL set quotient sign = sign(dividend) XOR sign(divisor), except a zero magnitude result SHALL have sign 0.
REQ-021 SHALL, when D==0 at acceptance, skip CALC, enter DONE after edge k+1, assert div_zero, and output quotient = {sign(dividend), all ones}; overflow SHALL be 0 in this case.
REQ-022 SHALL hold quotient, div_zero, overflow and out_valid stable in DONE while out_ready is low.
REQ-023 SHALL return to IDLE on the edge where out_valid & out_ready; no new operand is accepted on that same edge (one-cycle IDLE gap minimum).
REQ-024 SHALL ignore in_valid while busy; upstream must hold operands until in_ready.

Reset
REQ-025 SHALL, on rst high at any time, including mid-CALC or in DONE, immediately enter IDLE with in_ready=1, out_valid=0, busy=0, quotient=0, div_zero=0, overflow=0, discarding any operation in progress.
REQ-026 SHALL accept new operands on the first rising edge after rst is deasserted.

Configuration
REQ-027 SHALL, with macro QDIV_ROUND_EN defined, run one extra iteration (latency ITER+1) yielding a guard bit, add guard to the magnitude (round half away from zero), and set overflow/saturate if the increment carries out of WIDTH-1 bits.
REQ-028 SHALL, without QDIV_ROUND_EN, truncate the magnitude toward zero with latency ITER.

Verification (WIDTH=32, FBITS=16)
REQ-029 SHALL cover 0x00080000 / 0x00020000 -> quotient 0x00040000, div_zero=0, overflow=0, out_valid 47 edges after accept (48 with QDIV_ROUND_EN).
REQ-030 SHALL cover 0x00020000 / 0x00030000 -> 0x0000AAAA without QDIV_ROUND_EN, 0x0000AAAB with it; 0x80060000 / 0x00030000 -> 0x80020000; 0x80060000 / 0x80020000 -> 0x00030000.
REQ-031 SHALL cover 0x00050000 / 0x00000000 -> div_zero=1, quotient 0x7FFFFFFF, out_valid after one edge; 0x40000000 / 0x00000100 -> overflow=1, quotient 0x7FFFFFFF.
REQ-032 SHALL cover 0x80000000 / 0x00010000 -> quotient 0x00000000 (sign forced 0).
REQ-033 SHALL cover backpressure: out_ready low 10 cycles in DONE -> outputs stable, in_ready=0; then out_ready high -> IDLE next edge.
REQ-034 SHALL cover rst pulse at iteration 20 of CALC -> IDLE immediately, all outputs zero, next operands produce correct result.

Source files
------------

// File: rtl/qdiv_hs.sv
// qdiv_hs: sign-magnitude fixed-point restoring divider with a valid/ready handshake.
// Define QDIV_ROUND_EN to add a guard iteration and round half away from zero.
module qdiv_hs #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             div_zero,
  output logic             overflow,
  output logic             busy
);
  localparam int MW = WIDTH - 1;
  localparam int NW = MW + FBITS;
`ifdef QDIV_ROUND_EN
  localparam int GB = 1;
`else
  localparam int GB = 0;
`endif
  localparam int ITER = NW + GB;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ITER-1:0] r_nq;
  logic [MW-1:0]   r_rem;
  logic [MW-1:0]   r_den;
  logic [CW-1:0]   r_cnt;
  logic            r_sign_n;
  logic            r_sign_q;
  logic            r_dz;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [WIDTH-1:0] r_quotient;
  logic            r_div_zero;
  logic            r_overflow;

  logic [MW:0]     w_trial;
  logic [MW:0]     w_diff;
  logic            w_qbit;
  logic [MW-1:0]   w_rem_nxt;
  logic [ITER-1:0] w_nq_nxt;
  logic [MW-1:0]   w_mag;
  logic            w_ovf;
`ifdef QDIV_ROUND_EN
  logic [MW:0]     w_rnd;
`endif

  // One restoring step: r_nq shifts the numerator out of its top and quotient bits into its bottom.
  always_comb begin
    w_trial   = {r_rem, r_nq[ITER-1]};
    w_diff    = w_trial - {1'b0, r_den};
    w_qbit    = ~w_diff[MW];
    w_rem_nxt = w_qbit ? w_diff[MW-1:0] : w_trial[MW-1:0];
    w_nq_nxt  = {r_nq[ITER-2:0], w_qbit};
  end

  // Final magnitude from the completed quotient, saturating when it does not fit MW bits.
  always_comb begin
`ifdef QDIV_ROUND_EN
    w_rnd = {1'b0, w_nq_nxt[MW:1]} + {{MW{1'b0}}, w_nq_nxt[0]};
    w_ovf = (|w_nq_nxt[ITER-1:MW+1]) | w_rnd[MW];
    w_mag = w_ovf ? {MW{1'b1}} : w_rnd[MW-1:0];
`else
    w_ovf = |w_nq_nxt[ITER-1:MW];
    w_mag = w_ovf ? {MW{1'b1}} : w_nq_nxt[MW-1:0];
`endif
  end

  // Next-state logic; a zero divisor spends a single CALC cycle instead of ITER.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = CALC;
        else          w_state_nxt = IDLE;
      end
      CALC: begin
        if (r_dz || (r_cnt == LAST)) w_state_nxt = DONE;
        else                         w_state_nxt = CALC;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
        else           w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nq        <= '0;
      r_rem       <= '0;
      r_den       <= '0;
      r_cnt       <= '0;
      r_sign_n    <= 1'b0;
      r_sign_q    <= 1'b0;
      r_dz        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_quotient  <= '0;
      r_div_zero  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_nq     <= {dividend[MW-1:0], {(FBITS + GB){1'b0}}};
            r_rem    <= '0;
            r_den    <= divisor[MW-1:0];
            r_cnt    <= '0;
            r_sign_n <= dividend[MW];
            r_sign_q <= dividend[MW] ^ divisor[MW];
            r_dz     <= ~(|divisor[MW-1:0]);
          end
        end
        CALC: begin
          if (r_dz) begin
            r_quotient <= {r_sign_n, {MW{1'b1}}};
            r_div_zero <= 1'b1;
            r_overflow <= 1'b0;
          end else begin
            r_nq  <= w_nq_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (r_cnt == LAST) begin
              // A zero magnitude is always reported as +0.
              r_quotient <= {r_sign_q & (|w_mag), w_mag};
              r_div_zero <= 1'b0;
              r_overflow <= w_ovf;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign quotient  = r_quotient;
  assign div_zero  = r_div_zero;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_qdiv_hs.sv
// Self-checking bench for qdiv_hs (WIDTH=32, FBITS=16): directed spec vectors plus random
// operands checked against an arithmetic reference model.
module tb_qdiv_hs;
`ifdef QDIV_ROUND_EN
  localparam int EXP_LAT = 48;
`else
  localparam int EXP_LAT = 47;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        div_zero;
  logic        overflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  qdiv_hs #(.WIDTH(32), .FBITS(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .div_zero(div_zero), .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer division of the magnitudes, then saturation and sign rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic dz, output logic ov);
    logic [63:0] n;
    logic [63:0] d;
    logic [63:0] r;
    n = 64'(a[30:0]) << 16;
    d = 64'(b[30:0]);
    if (d == 64'd0) begin
      q  = {a[31], 31'h7FFFFFFF};
      dz = 1'b1;
      ov = 1'b0;
    end else begin
`ifdef QDIV_ROUND_EN
      r = (((n << 1) / d) + 64'd1) >> 1;
`else
      r = n / d;
`endif
      dz = 1'b0;
      ov = (r >= 64'h80000000);
      if (ov) r = 64'h7FFFFFFF;
      else    r = r;
      q = {(a[31] ^ b[31]) && (r != 64'd0), r[30:0]};
    end
  endfunction

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // One full transaction: accept, measure latency, check result, optional backpressure, release.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic edz, input logic eov,
                     input int elat, input int hold);
    int lat;
    logic [63:0] snap;
    wait_ready(tag);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Junk on the inputs while busy must not disturb the operation.
    dividend = $urandom;
    divisor  = $urandom;
    check({tag, "/busy"}, 64'({busy, in_ready}), 64'd2);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(elat));
    check({tag, "/quotient"}, 64'(quotient), 64'(eq));
    check({tag, "/flags"}, 64'({div_zero, overflow}), 64'({edz, eov}));
    snap = 64'({out_valid, in_ready, busy, div_zero, overflow, quotient});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold"}, 64'({out_valid, in_ready, busy, div_zero, overflow, quotient}), snap);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "/release"}, 64'({out_valid, in_ready, busy}), 64'd2);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mq;
    logic        mdz;
    logic        mov;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = 32'd0;
    divisor = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_state", 64'({in_ready, out_valid, busy, div_zero, overflow, quotient}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}));
    rst = 1'b0;

    run("div_4", 32'h00080000, 32'h00020000, 32'h00040000, 1'b0, 1'b0, EXP_LAT, 0);
`ifdef QDIV_ROUND_EN
    run("two_thirds", 32'h00020000, 32'h00030000, 32'h0000AAAB, 1'b0, 1'b0, EXP_LAT, 0);
`else
    run("two_thirds", 32'h00020000, 32'h00030000, 32'h0000AAAA, 1'b0, 1'b0, EXP_LAT, 0);
`endif
    run("neg_pos", 32'h80060000, 32'h00030000, 32'h80020000, 1'b0, 1'b0, EXP_LAT, 0);
    run("neg_neg_bp", 32'h80060000, 32'h80020000, 32'h00030000, 1'b0, 1'b0, EXP_LAT, 10);
    run("div_zero", 32'h00050000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1, 2);
    run("div_zero_neg", 32'h80050000, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1, 0);
    run("overflow", 32'h40000000, 32'h00000100, 32'h7FFFFFFF, 1'b0, 1'b1, EXP_LAT, 0);

    // Reset pulse after 20 iterations of CALC.
    wait_ready("rst_mid");
    in_valid = 1'b1;
    dividend = 32'h00070000;
    divisor  = 32'h00020000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid/outputs", 64'({in_ready, out_valid, busy, div_zero, overflow, quotient}),
             64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}));
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 32'h00080000, 32'h00020000, 32'h00040000, 1'b0, 1'b0, EXP_LAT, 0);

    run("neg_zero", 32'h80000000, 32'h00010000, 32'h00000000, 1'b0, 1'b0, EXP_LAT, 0);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 24);
      if (i == 3) rb = rb & 32'h80000000;
      else        rb = rb;
      model(ra, rb, mq, mdz, mov);
      run($sformatf("rand%0d", i), ra, rb, mq, mdz, mov, mdz ? 1 : EXP_LAT,
          int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
